// File: rtl/imm_extend_unit.sv
// imm_extend_unit
//   Buffered immediate extender for the MIPS datapath. An IMM_WIDTH immediate
//   is widened to DATA_WIDTH in one of four modes and the result is queued in a
//   DEPTH-entry FIFO that feeds the ALU / branch-target operand mux.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   immediate/mode presented by decode
//   in_ready   unit can accept a new immediate this cycle (FIFO not full)
//   in_imm     raw immediate field
//   in_mode    00 sign, 01 zero, 10 upper (LUI), 11 branch offset
//   out_valid  FIFO head holds a result
//   out_ready  consumer takes the head this cycle
//   out_data   extended result at the FIFO head (0 when empty)
//   count      current FIFO occupancy
module imm_extend_unit #(
  parameter int IMM_WIDTH  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IMM_WIDTH-1:0]         in_imm,
  input  logic [1:0]                   in_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int EXT_W = DATA_WIDTH - IMM_WIDTH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } imm_mode_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [DATA_WIDTH-1:0] ext_sign;
  logic [DATA_WIDTH-1:0] ext_result;
  logic                  push;
  logic                  pop;

  // Pointers step through 0..DEPTH-1, so non-power-of-two depths wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Handshake flags. in_ready only looks at occupancy: a full FIFO never
  // accepts, even if the consumer is popping in the same cycle.
  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Extension arithmetic. Branch offsets are word offsets, so the sign-extended
  // value is shifted left by two and the top bits simply fall off.
  always_comb begin
    ext_sign   = {{EXT_W{in_imm[IMM_WIDTH-1]}}, in_imm};
    ext_result = ext_sign;
    case (imm_mode_e'(in_mode))
      MODE_SIGN:   ext_result = ext_sign;
      MODE_ZERO:   ext_result = {{EXT_W{1'b0}}, in_imm};
      MODE_UPPER:  ext_result = {in_imm, {EXT_W{1'b0}}};
      MODE_BRANCH: ext_result = {ext_sign[DATA_WIDTH-3:0], 2'b00};
      default:     ext_result = ext_sign;
    endcase
  end

  // Storage is deliberately not cleared on reset; the pointers and count
  // define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= ext_result;
    end
  end

  // Pointer and occupancy bookkeeping; reset wins over any concurrent push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit
//   Self-checking bench for imm_extend_unit (IMM_WIDTH=16, DATA_WIDTH=32,
//   DEPTH=2). A table of spec vectors, hand-written FIFO corner sequences and
//   a randomized run are all compared against a queue-based reference model.
module tb_imm_extend_unit;

  localparam int IW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_imm;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] modelQ [$];

  typedef struct {
    logic [IW-1:0] imm;
    logic [1:0]    mode;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [10];

  imm_extend_unit #(.IMM_WIDTH(IW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Reference extension computed from the numeric meaning of each mode.
  function automatic logic [DW-1:0] refExtend(input logic [IW-1:0] imm, input logic [1:0] mode);
    longint s;
    longint v;
    s = (longint'(imm) >= (longint'(1) << (IW - 1))) ? longint'(imm) - (longint'(1) << IW) : longint'(imm);
    case (mode)
      2'd0:    v = s;
      2'd1:    v = longint'(imm);
      2'd2:    v = longint'(imm) * (longint'(1) << (DW - IW));
      default: v = s * 4;
    endcase
    return v[DW-1:0];
  endfunction

  task automatic checkValue(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model's current FIFO state.
  task automatic checkOutput();
    int n;
    n = modelQ.size();
    checkValue("in_ready",  DW'(in_ready),  DW'(n < DEPTH));
    checkValue("out_valid", DW'(out_valid), DW'(n != 0));
    checkValue("out_data",  out_data,       (n != 0) ? modelQ[0] : '0);
    checkValue("count",     DW'(count),     DW'(n));
  endtask

  task automatic applyStimulus(input logic v, input logic [IW-1:0] imm, input logic [1:0] mode,
                               input logic ordy, input logic rst);
    in_valid  = v;
    in_imm    = imm;
    in_mode   = mode;
    out_ready = ordy;
    reset     = rst;
  endtask

  // One clock: drive, check at negedge, then advance the model across the edge.
  task automatic step(input logic v, input logic [IW-1:0] imm, input logic [1:0] mode,
                      input logic ordy, input logic rst);
    bit doPush;
    bit doPop;
    applyStimulus(v, imm, mode, ordy, rst);
    @(negedge clk);
    checkOutput();
    doPush = v && (modelQ.size() < DEPTH);
    doPop  = ordy && (modelQ.size() > 0);
    @(posedge clk);
    if (rst) begin
      modelQ.delete();
    end else begin
      if (doPop) void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(refExtend(imm, mode));
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 2'd0, 1'b1, 1'b0);
  endtask

  initial begin
    vecs[0] = '{16'h8004, 2'd0, 32'hFFFF8004};
    vecs[1] = '{16'h8004, 2'd1, 32'h00008004};
    vecs[2] = '{16'h8004, 2'd2, 32'h80040000};
    vecs[3] = '{16'h8004, 2'd3, 32'hFFFE0010};
    vecs[4] = '{16'h7FFF, 2'd0, 32'h00007FFF};
    vecs[5] = '{16'h0001, 2'd3, 32'h00000004};
    vecs[6] = '{16'hFFFF, 2'd1, 32'h0000FFFF};
    vecs[7] = '{16'hFFFF, 2'd2, 32'hFFFF0000};
    vecs[8] = '{16'h0000, 2'd0, 32'h00000000};
    vecs[9] = '{16'h7FFF, 2'd3, 32'h0001FFFC};

    // Initial reset: outputs are unknown before the first edge, so no model check yet.
    applyStimulus(1'b0, '0, 2'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_count",     DW'(count),     32'd0);
    checkValue("reset_out_valid", DW'(out_valid), 32'd0);
    checkValue("reset_out_data",  out_data,       32'd0);
    checkValue("reset_in_ready",  DW'(in_ready),  32'd1);

    // Spec vectors, each visible one cycle after its push.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, vecs[i].imm, vecs[i].mode, 1'b1, 1'b0);
      #3;
      checkValue($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      checkValue($sformatf("vec%0d_valid", i), DW'(out_valid), 32'd1);
    end
    drain();

    // Fill to full with the consumer stalled; the third item is held off.
    step(1'b1, 16'h1234, 2'd0, 1'b0, 1'b0);
    step(1'b1, 16'hF000, 2'd1, 1'b0, 1'b0);
    #3;
    checkValue("full_count",    DW'(count),    32'd2);
    checkValue("full_in_ready", DW'(in_ready), 32'd0);
    step(1'b1, 16'h0005, 2'd2, 1'b0, 1'b0);
    #3;
    checkValue("held_count", DW'(count), 32'd2);
    checkValue("held_head",  out_data,   32'h00001234);
    step(1'b0, '0, 2'd0, 1'b1, 1'b0);
    #3;
    checkValue("pop1_in_ready", DW'(in_ready), 32'd1);
    checkValue("pop1_head",     out_data,      32'h0000F000);
    step(1'b0, '0, 2'd0, 1'b1, 1'b0);
    #3;
    checkValue("pop2_out_valid", DW'(out_valid), 32'd0);

    // Simultaneous push and pop at count=1, then a run long enough to wrap pointers.
    step(1'b1, 16'h00AA, 2'd0, 1'b0, 1'b0);
    step(1'b1, 16'h8001, 2'd3, 1'b1, 1'b0);
    #3;
    checkValue("pp_count", DW'(count), 32'd1);
    checkValue("pp_head",  out_data,   32'hFFFE0004);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'(i * 3 + 1), 2'd1, 1'b1, 1'b0);
      #3;
      checkValue($sformatf("wrap%0d_head", i), out_data, 32'(i * 3 + 1));
      checkValue($sformatf("wrap%0d_count", i), DW'(count), 32'd1);
    end
    drain();

    // Reset while full with a push pending drops everything.
    step(1'b1, 16'h1111, 2'd0, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 2'd0, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 2'd0, 1'b0, 1'b1);
    #3;
    checkValue("rst_count",     DW'(count),     32'd0);
    checkValue("rst_out_valid", DW'(out_valid), 32'd0);
    checkValue("rst_out_data",  out_data,       32'd0);
    checkValue("rst_in_ready",  DW'(in_ready),  32'd1);

    // Popping an empty FIFO is a no-op; a later push still emerges correctly.
    for (int i = 0; i < 3; i++) step(1'b0, '0, 2'd0, 1'b1, 1'b0);
    #3;
    checkValue("empty_count", DW'(count), 32'd0);
    step(1'b1, 16'hFFFF, 2'd0, 1'b0, 1'b0);
    #3;
    checkValue("after_empty_head",  out_data,   32'hFFFFFFFF);
    checkValue("after_empty_count", DW'(count), 32'd1);
    drain();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
    end
    step(1'b0, '0, 2'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
